// File: rtl/pc_gen_pkg.sv
// Types shared by the program-counter generator and its users: redirect sources,
// exception target selects and the exception cause encoding.
package pc_gen_pkg;

    typedef enum logic [2:0] {
        PC_BOOT = 3'd0,
        PC_JUMP = 3'd1,
        PC_EXC  = 3'd2,
        PC_ERET = 3'd3,
        PC_DRET = 3'd4,
        PC_BP   = 3'd5
    } pc_sel_e;

    typedef enum logic [1:0] {
        EXC_PC_EXC     = 2'd0,
        EXC_PC_IRQ     = 2'd1,
        EXC_PC_DBD     = 2'd2,
        EXC_PC_DBG_EXC = 2'd3
    } exc_pc_sel_e;

    typedef struct packed {
        logic       irq_ext;
        logic       irq_int;
        logic [5:0] lower_cause;
    } exc_cause_t;

    // Internal NMI lands in the last vector slot of a 32-entry table
    localparam exc_cause_t ExcCauseIrqNm = '{irq_ext: 1'b0, irq_int: 1'b1, lower_cause: 6'd31};

endpackage

// File: rtl/pc_gen.sv
// Program-counter generator: registered fetch request with redirect, predictor and
// sequential paths. Optional return-address stack is built when PC_GEN_RAS_EN is defined.
//
// state | meaning
// IDLE  | out of reset, no fetch request issued yet
// RUN   | fetch request always valid; address advances on handshake or redirect
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] DmHaltAddr      = 32'h1A110800,
    parameter logic [31:0] DmExceptionAddr = 32'h1A110808,
    parameter int unsigned NumIrqVec       = 32,
    parameter int unsigned RasDepth        = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] boot_addr_i,
    input  logic        pc_set_i,
    input  pc_sel_e     pc_mux_i,
    input  exc_pc_sel_e exc_pc_mux_i,
    input  exc_cause_t  exc_cause_i,
    input  logic [31:0] branch_target_ex_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_depc_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic        predict_branch_taken_i,
    input  logic [31:0] predict_branch_pc_i,
    input  logic        instr_compressed_i,
    input  logic        ras_push_i,
    input  logic        ras_pop_i,
    input  logic        fetch_ready_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_addr_o,
    output logic        redirect_o,
    output logic        csr_mtvec_init_o
);

    localparam int unsigned IdxW = $clog2(NumIrqVec);

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] addr_q, addr_d;
    logic        redir_q, redir_d;

    logic        handshake;
    logic [31:0] seq_addr;
    logic [5:0]  cause_sel;
    logic [IdxW-1:0] irq_idx;
    logic [31:0] mtvec_base;
    logic [31:0] exc_target;
    logic [31:0] set_target;
    logic        ras_hit;
    logic [31:0] ras_top;

    assign handshake        = valid_q & fetch_ready_i;
    assign seq_addr         = addr_q + (instr_compressed_i ? 32'd2 : 32'd4);
    assign csr_mtvec_init_o = pc_set_i & (pc_mux_i == PC_BOOT);

    // NMI vector index is fixed regardless of the incoming cause code
    assign cause_sel  = exc_cause_i.irq_int ? ExcCauseIrqNm.lower_cause : exc_cause_i.lower_cause;
    assign irq_idx    = cause_sel[IdxW-1:0];
    assign mtvec_base = {csr_mtvec_i[31:8], 8'h00};

    always_comb begin
        exc_target = mtvec_base;
        case (exc_pc_mux_i)
            EXC_PC_EXC:     exc_target = mtvec_base;
            EXC_PC_IRQ:     exc_target = mtvec_base + (32'(irq_idx) << 2);
            EXC_PC_DBD:     exc_target = DmHaltAddr;
            EXC_PC_DBG_EXC: exc_target = DmExceptionAddr;
            default:        exc_target = mtvec_base;
        endcase
    end

    always_comb begin
        set_target = {boot_addr_i[31:8], 8'h80};
        case (pc_mux_i)
            PC_BOOT: set_target = {boot_addr_i[31:8], 8'h80};
            PC_JUMP: set_target = branch_target_ex_i;
            PC_EXC:  set_target = exc_target;
            PC_ERET: set_target = csr_mepc_i;
            PC_DRET: set_target = csr_depc_i;
            PC_BP:   set_target = predict_branch_pc_i;
            default: set_target = {boot_addr_i[31:8], 8'h80};
        endcase
    end

`ifdef PC_GEN_RAS_EN
    localparam int unsigned PtrW = $clog2(RasDepth);
    localparam logic [PtrW:0] RasFull = (PtrW+1)'(RasDepth);

    logic [31:0]     ras_q [RasDepth];
    logic [PtrW-1:0] ras_ptr_q;
    logic [PtrW-1:0] ras_top_ptr;
    logic [PtrW:0]   ras_cnt_q;
    logic            ras_do_push;
    logic            ras_clear;

    assign ras_top_ptr = ras_ptr_q - PtrW'(1);
    assign ras_top     = ras_q[ras_top_ptr];
    assign ras_hit     = handshake & ~pc_set_i & ras_pop_i & (ras_cnt_q != '0);
    assign ras_do_push = handshake & ~pc_set_i & ras_push_i;
    assign ras_clear   = pc_set_i & ((pc_mux_i == PC_BOOT) | (pc_mux_i == PC_EXC));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else if (ras_clear) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else if (ras_do_push && !ras_hit) begin
            ras_ptr_q <= ras_ptr_q + PtrW'(1);
            if (ras_cnt_q != RasFull) begin
                ras_cnt_q <= ras_cnt_q + (PtrW+1)'(1);
            end
        end else if (ras_hit && !ras_do_push) begin
            ras_ptr_q <= ras_top_ptr;
            ras_cnt_q <= ras_cnt_q - (PtrW+1)'(1);
        end
    end

    // Storage needs no reset: occupancy is tracked by ras_cnt_q alone
    always_ff @(posedge clk_i) begin
        if (!ras_clear && ras_do_push) begin
            if (ras_hit) begin
                ras_q[ras_top_ptr] <= seq_addr;
            end else begin
                ras_q[ras_ptr_q] <= seq_addr;
            end
        end
    end
`else
    logic unused_ras;

    assign ras_hit    = 1'b0;
    assign ras_top    = '0;
    assign unused_ras = ras_push_i ^ ras_pop_i;
`endif

    logic unused_bits;
    assign unused_bits = ^{boot_addr_i[7:0], csr_mtvec_i[7:0], exc_cause_i.irq_ext, cause_sel};

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        redir_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pc_set_i) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                    addr_d  = set_target;
                    redir_d = 1'b1;
                end
            end
            RUN: begin
                valid_d = 1'b1;
                if (pc_set_i) begin
                    addr_d  = set_target;
                    redir_d = 1'b1;
                end else if (handshake) begin
                    if (ras_hit) begin
                        addr_d  = ras_top;
                        redir_d = 1'b1;
                    end else if (predict_branch_taken_i) begin
                        addr_d  = predict_branch_pc_i;
                        redir_d = 1'b1;
                    end else begin
                        addr_d  = seq_addr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            redir_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            redir_q <= redir_d;
        end
    end

    assign fetch_valid_o = valid_q;
    assign fetch_addr_o  = addr_q;
    assign redirect_o    = redir_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: the driver queues the expected fetch request for each
// cycle, and a negedge monitor pops and compares whenever fetch_valid_o is high.
module tb_pc_gen;
    import pc_gen_pkg::*;

    logic        clk_sys;
    logic        rst_b;
    logic [31:0] boot_addr;
    logic        pc_set;
    pc_sel_e     pc_mux;
    exc_pc_sel_e exc_mux;
    exc_cause_t  exc_cause;
    logic [31:0] branch_target;
    logic [31:0] mepc;
    logic [31:0] depc;
    logic [31:0] mtvec;
    logic        predict_taken;
    logic [31:0] predict_pc;
    logic        compressed;
    logic        ras_push;
    logic        ras_pop;
    logic        ready;
    logic        fetch_valid_o;
    logic [31:0] fetch_addr_o;
    logic        redirect_o;
    logic        csr_mtvec_init_o;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        redir;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    pc_gen dut (
        .clk_i                  (clk_sys),
        .rst_ni                 (rst_b),
        .boot_addr_i            (boot_addr),
        .pc_set_i               (pc_set),
        .pc_mux_i               (pc_mux),
        .exc_pc_mux_i           (exc_mux),
        .exc_cause_i            (exc_cause),
        .branch_target_ex_i     (branch_target),
        .csr_mepc_i             (mepc),
        .csr_depc_i             (depc),
        .csr_mtvec_i            (mtvec),
        .predict_branch_taken_i (predict_taken),
        .predict_branch_pc_i    (predict_pc),
        .instr_compressed_i     (compressed),
        .ras_push_i             (ras_push),
        .ras_pop_i              (ras_pop),
        .fetch_ready_i          (ready),
        .fetch_valid_o          (fetch_valid_o),
        .fetch_addr_o           (fetch_addr_o),
        .redirect_o             (redirect_o),
        .csr_mtvec_init_o       (csr_mtvec_init_o)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (rst_b && fetch_valid_o) begin
            exp_t e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_fetch: addr=%h redirect=%b but no expectation queued",
                         fetch_addr_o, redirect_o);
            end else begin
                e = exp_q.pop_front();
                if (fetch_addr_o !== e.addr || redirect_o !== e.redir) begin
                    n_bad++;
                    $display("FAIL %s: got addr=%h redirect=%b, expected addr=%h redirect=%b",
                             e.name, fetch_addr_o, redirect_o, e.addr, e.redir);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock; the request registered at this edge is either queued or must be invalid
    task automatic tick(input string name, input logic exp_v, input logic [31:0] exp_a,
                        input logic exp_r);
        @(posedge clk_sys);
        #1;
        if (exp_v) exp_q.push_back('{name: name, addr: exp_a, redir: exp_r});
        else chk({name, "_valid"}, 32'(fetch_valid_o), 32'd0);
    endtask

    initial begin
        rst_b         = 1'b0;
        boot_addr     = '0;
        pc_set        = 1'b0;
        pc_mux        = PC_BOOT;
        exc_mux       = EXC_PC_EXC;
        exc_cause     = '0;
        branch_target = '0;
        mepc          = '0;
        depc          = '0;
        mtvec         = '0;
        predict_taken = 1'b0;
        predict_pc    = '0;
        compressed    = 1'b0;
        ras_push      = 1'b0;
        ras_pop       = 1'b0;
        ready         = 1'b0;

        #2;
        chk("rst_valid", 32'(fetch_valid_o), 32'd0);
        chk("rst_addr", fetch_addr_o, 32'd0);
        chk("rst_redirect", 32'(redirect_o), 32'd0);
        @(negedge clk_sys);
        rst_b = 1'b1;
        tick("idle", 1'b0, 32'd0, 1'b0);
        tick("idle2", 1'b0, 32'd0, 1'b0);

        // Boot redirect
        boot_addr = 32'h0000_1000;
        pc_set    = 1'b1;
        pc_mux    = PC_BOOT;
        #1;
        chk("mtvec_init_set", 32'(csr_mtvec_init_o), 32'd1);
        tick("boot", 1'b1, 32'h0000_1080, 1'b1);
        pc_set = 1'b0;
        #1;
        chk("mtvec_init_clr", 32'(csr_mtvec_init_o), 32'd0);
        tick("boot_hold", 1'b1, 32'h0000_1080, 1'b0);

        // Sequential stepping, mixed widths, then stall
        boot_addr = 32'h0000_0000;
        pc_set    = 1'b1;
        tick("boot_80", 1'b1, 32'h0000_0080, 1'b1);
        pc_set     = 1'b0;
        ready      = 1'b1;
        compressed = 1'b1;
        tick("seq_82", 1'b1, 32'h0000_0082, 1'b0);
        compressed = 1'b0;
        tick("seq_86", 1'b1, 32'h0000_0086, 1'b0);
        ready = 1'b0;
        tick("stall_86a", 1'b1, 32'h0000_0086, 1'b0);
        tick("stall_86b", 1'b1, 32'h0000_0086, 1'b0);

        // Exception targets, redirect must not wait for ready
        pc_set    = 1'b1;
        pc_mux    = PC_EXC;
        mtvec     = 32'h0000_4000;
        exc_mux   = EXC_PC_IRQ;
        exc_cause = '{irq_ext: 1'b0, irq_int: 1'b0, lower_cause: 6'd7};
        tick("irq_7", 1'b1, 32'h0000_401C, 1'b1);
        exc_cause = '{irq_ext: 1'b0, irq_int: 1'b1, lower_cause: 6'd7};
        tick("irq_nm", 1'b1, 32'h0000_407C, 1'b1);
        exc_cause = '{irq_ext: 1'b1, irq_int: 1'b0, lower_cause: 6'd40};
        tick("irq_mod", 1'b1, 32'h0000_4020, 1'b1);
        exc_mux = EXC_PC_EXC;
        mtvec   = 32'h0000_4055;
        tick("exc_base", 1'b1, 32'h0000_4000, 1'b1);
        exc_mux = EXC_PC_DBD;
        tick("dbg_halt", 1'b1, 32'h1A11_0800, 1'b1);
        exc_mux = EXC_PC_DBG_EXC;
        tick("dbg_exc", 1'b1, 32'h1A11_0808, 1'b1);

        // Remaining redirect sources
        pc_mux = PC_ERET;
        mepc   = 32'h0000_5550;
        tick("eret", 1'b1, 32'h0000_5550, 1'b1);
        pc_mux = PC_DRET;
        depc   = 32'h0000_6660;
        tick("dret", 1'b1, 32'h0000_6660, 1'b1);
        pc_mux     = PC_BP;
        predict_pc = 32'h0000_7770;
        tick("bp", 1'b1, 32'h0000_7770, 1'b1);
        pc_mux    = pc_sel_e'(3'd7);
        boot_addr = 32'h0000_ABCD;
        tick("sel_default", 1'b1, 32'h0000_AB80, 1'b1);

        // pc_set beats the predictor; predictor applies only on handshake
        pc_mux        = PC_JUMP;
        branch_target = 32'h0000_2000;
        predict_taken = 1'b1;
        predict_pc    = 32'h0000_3000;
        tick("jump_over_bp", 1'b1, 32'h0000_2000, 1'b1);
        pc_set = 1'b0;
        tick("bp_no_hs", 1'b1, 32'h0000_2000, 1'b0);
        ready = 1'b1;
        tick("bp_taken", 1'b1, 32'h0000_3000, 1'b1);
        predict_taken = 1'b0;
        tick("after_bp", 1'b1, 32'h0000_3004, 1'b0);

        // Address wrap
        ready         = 1'b0;
        pc_set        = 1'b1;
        branch_target = 32'hFFFF_FFFE;
        tick("jump_top", 1'b1, 32'hFFFF_FFFE, 1'b1);
        pc_set     = 1'b0;
        ready      = 1'b1;
        compressed = 1'b1;
        tick("wrap", 1'b1, 32'h0000_0000, 1'b0);
        compressed = 1'b0;
        tick("post_wrap", 1'b1, 32'h0000_0004, 1'b0);

`ifndef PC_GEN_RAS_EN
        ras_push = 1'b1;
        tick("push_ignored", 1'b1, 32'h0000_0008, 1'b0);
        ras_push = 1'b0;
        ras_pop  = 1'b1;
        tick("pop_ignored", 1'b1, 32'h0000_000C, 1'b0);
        ras_pop = 1'b0;
`else
        ready         = 1'b0;
        pc_set        = 1'b1;
        branch_target = 32'h0000_0100;
        tick("ras_start", 1'b1, 32'h0000_0100, 1'b1);
        pc_set   = 1'b0;
        ready    = 1'b1;
        ras_push = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick($sformatf("ras_push%0d", i), 1'b1, 32'h0000_0100 + 32'(4 * i), 1'b0);
        end
        ras_push = 1'b0;
        ras_pop  = 1'b1;
        tick("ras_pop1", 1'b1, 32'h0000_0114, 1'b1);
        tick("ras_pop2", 1'b1, 32'h0000_0110, 1'b1);
        tick("ras_pop3", 1'b1, 32'h0000_010C, 1'b1);
        tick("ras_pop4", 1'b1, 32'h0000_0108, 1'b1);
        tick("ras_pop_empty", 1'b1, 32'h0000_010C, 1'b0);
        ras_pop  = 1'b0;
        ras_push = 1'b1;
        tick("ras_push_again", 1'b1, 32'h0000_0110, 1'b0);
        ras_push  = 1'b0;
        pc_set    = 1'b1;
        pc_mux    = PC_BOOT;
        boot_addr = 32'h0000_0000;
        tick("ras_boot_clear", 1'b1, 32'h0000_0080, 1'b1);
        pc_set  = 1'b0;
        ras_pop = 1'b1;
        tick("ras_pop_cleared", 1'b1, 32'h0000_0084, 1'b0);
        ras_pop = 1'b0;
`endif

        @(negedge clk_sys);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of operation
        rst_b = 1'b0;
        #1;
        chk("midrst_valid", 32'(fetch_valid_o), 32'd0);
        chk("midrst_addr", fetch_addr_o, 32'd0);
        chk("midrst_redirect", 32'(redirect_o), 32'd0);
        ready = 1'b0;
        @(negedge clk_sys);
        rst_b = 1'b1;
        tick("post_rst_idle", 1'b0, 32'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
